sdp_x_x_alu_core_cfg_alu_src_triosy_host: RTL and testbench



---
 rtl/sdp_x_x_alu_core_cfg_alu_src_triosy_host.sv | 152 +++++++++++++++
 tb/tb_sdp_x_x_alu_core_cfg_alu_src_triosy_host.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sdp_x_x_alu_core_cfg_alu_src_triosy_host.sv
// Configuration-source end of the cfg_alu_src triosy handshake into the
// SDP X alu core. Software writes a staging copy of alu_src; a layer start
// (op_en) copies it into the active register that drives rsc_z for the
// whole layer, and the core's triosy_lz pulses are counted until the
// per-layer target is reached, the watchdog expires, or reset intervenes.
//
// Handshake: the value on cfg_alu_src_rsc_z is always valid while busy and
// never changes while busy; the core signals consumption by holding
// cfg_alu_src_rsc_triosy_lz high for one cycle per consumed value. There is
// no back-pressure toward the core: every lz cycle in ACTIVE counts, and lz
// outside ACTIVE is flagged as spurious rather than counted.
module sdp_x_x_alu_core_cfg_alu_src_triosy_host #(
  parameter int CFG_W   = 1,
  parameter int CNT_W   = 16,
  parameter int TMO_W   = 12,
  parameter int TIMEOUT = 4095
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             reg_wr_en,
  input  logic [CFG_W-1:0] reg_wr_data,
  input  logic             op_en,
  input  logic [CNT_W-1:0] cfg_ack_num,
  input  logic             err_clr,
  output logic [CFG_W-1:0] cfg_alu_src_rsc_z,
  input  logic             cfg_alu_src_rsc_triosy_lz,
  output logic             busy,
  output logic             layer_done,
  output logic [CNT_W-1:0] ack_cnt,
  output logic             err_timeout,
  output logic             err_spurious,
  output logic             err_op_drop
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  // Last watchdog value before expiry; TIMEOUT counts ACTIVE cycles with no lz.
  localparam logic [TMO_W-1:0] WD_LAST = TMO_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [TMO_W-1:0] WD_ONE  = TMO_W'(1);

  state_t           state;
  logic [CFG_W-1:0] staging;
  logic [CNT_W-1:0] target;
  logic [TMO_W-1:0] watchdog;

  logic lz;
  logic last_ack;
  logic wd_expire;
  logic spurious_evt;
  logic op_drop_evt;

  assign lz = cfg_alu_src_rsc_triosy_lz;

  // The current lz completes the layer (ack_cnt still holds the pre-lz count).
  assign last_ack     = (ack_cnt == (target - CNT_ONE));
  // lz takes priority: an acknowledge in the expiry cycle rescues the layer.
  assign wd_expire    = (state == S_ACTIVE) && !lz && (watchdog == WD_LAST);
  assign spurious_evt = lz && (state != S_ACTIVE);
  assign op_drop_evt  = op_en && (state != S_IDLE);

  // Staging copy is writable at any time; it only reaches rsc_z at a layer start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      staging <= '0;
    end else if (reg_wr_en) begin
      staging <= reg_wr_data;
    end
  end

  // Layer FSM with registered busy/layer_done, active value, count and watchdog.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state             <= S_IDLE;
      busy              <= 1'b0;
      layer_done        <= 1'b0;
      cfg_alu_src_rsc_z <= '0;
      ack_cnt           <= '0;
      target            <= '0;
      watchdog          <= '0;
    end else begin
      layer_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (op_en) begin
            // A write in the start cycle bypasses staging into the new layer.
            cfg_alu_src_rsc_z <= reg_wr_en ? reg_wr_data : staging;
            target            <= cfg_ack_num;
            ack_cnt           <= '0;
            watchdog          <= '0;
            busy              <= 1'b1;
            if (cfg_ack_num != '0) begin
              state <= S_ACTIVE;
            end else begin
              // Nothing to consume: report completion straight away.
              state      <= S_DONE;
              layer_done <= 1'b1;
            end
          end
        end

        S_ACTIVE: begin
          if (lz) begin
            if (ack_cnt != CNT_MAX) begin
              ack_cnt <= ack_cnt + CNT_ONE;
            end
            watchdog <= '0;
            if (last_ack) begin
              state      <= S_DONE;
              layer_done <= 1'b1;
            end
          end else if (watchdog == WD_LAST) begin
            // Abandon the layer silently; ack_cnt keeps the partial count.
            state <= S_IDLE;
            busy  <= 1'b0;
          end else begin
            watchdog <= watchdog + WD_ONE;
          end
        end

        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end

        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Sticky error flags; a new event in the err_clr cycle keeps the flag set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_timeout  <= 1'b0;
      err_spurious <= 1'b0;
      err_op_drop  <= 1'b0;
    end else begin
      err_timeout  <= wd_expire    || (err_timeout  && !err_clr);
      err_spurious <= spurious_evt || (err_spurious && !err_clr);
      err_op_drop  <= op_drop_evt  || (err_op_drop  && !err_clr);
    end
  end

endmodule

// File: tb/tb_sdp_x_x_alu_core_cfg_alu_src_triosy_host.sv
// Bench for the cfg_alu_src triosy host: directed layer scenarios followed
// by random traffic, every cycle compared against a behavioural model of
// layers (running / finishing, acks still owed, quiet-cycle count).
module tb_sdp_x_x_alu_core_cfg_alu_src_triosy_host;

  localparam int CFG_W   = 1;
  localparam int CNT_W   = 16;
  localparam int TMO_W   = 12;
  localparam int TIMEOUT = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic             reg_wr_en;
  logic [CFG_W-1:0] reg_wr_data;
  logic             op_en;
  logic [CNT_W-1:0] cfg_ack_num;
  logic             err_clr;
  logic [CFG_W-1:0] cfg_alu_src_rsc_z;
  logic             cfg_alu_src_rsc_triosy_lz;
  logic             busy;
  logic             layer_done;
  logic [CNT_W-1:0] ack_cnt;
  logic             err_timeout;
  logic             err_spurious;
  logic             err_op_drop;

  sdp_x_x_alu_core_cfg_alu_src_triosy_host #(
    .CFG_W  (CFG_W),
    .CNT_W  (CNT_W),
    .TMO_W  (TMO_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk                      (clk),
    .rst                      (rst),
    .reg_wr_en                (reg_wr_en),
    .reg_wr_data              (reg_wr_data),
    .op_en                    (op_en),
    .cfg_ack_num              (cfg_ack_num),
    .err_clr                  (err_clr),
    .cfg_alu_src_rsc_z        (cfg_alu_src_rsc_z),
    .cfg_alu_src_rsc_triosy_lz(cfg_alu_src_rsc_triosy_lz),
    .busy                     (busy),
    .layer_done               (layer_done),
    .ack_cnt                  (ack_cnt),
    .err_timeout              (err_timeout),
    .err_spurious             (err_spurious),
    .err_op_drop              (err_op_drop)
  );

  // ---------------- check task ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit               m_running;    // layer waiting for acknowledges
  bit               m_finishing;  // completion cycle being reported
  int               m_cnt;
  int               m_target;
  int               m_quiet;      // consecutive running cycles without lz
  logic [CFG_W-1:0] m_active;
  logic [CFG_W-1:0] m_staging;
  bit               m_e_tmo, m_e_spur, m_e_drop;
  int               cnt_max = (1 << CNT_W) - 1;

  // Scoreboard: value each completed layer must have been driving.
  logic [CFG_W-1:0] exp_q[$];

  task automatic model_reset();
    m_running = 0; m_finishing = 0;
    m_cnt = 0; m_target = 0; m_quiet = 0;
    m_active = '0; m_staging = '0;
    m_e_tmo = 0; m_e_spur = 0; m_e_drop = 0;
  endtask

  task automatic model_step(input bit wr, input logic [CFG_W-1:0] wdata, input bit op,
                            input int num, input bit clr, input bit lz);
    bit spur, drop, tmo;
    spur = lz && !m_running;
    drop = op && (m_running || m_finishing);
    tmo  = 0;
    if (m_finishing) begin
      m_finishing = 0;
    end else if (m_running) begin
      if (lz) begin
        if (m_cnt < cnt_max) m_cnt++;
        m_quiet = 0;
        if (m_cnt == m_target) begin
          m_running = 0;
          m_finishing = 1;
          exp_q.push_back(m_active);
        end
      end else if (m_quiet + 1 == TIMEOUT) begin
        m_running = 0;
        tmo = 1;
      end else begin
        m_quiet++;
      end
    end else if (op) begin
      m_active = wr ? wdata : m_staging;
      m_target = num;
      m_cnt    = 0;
      m_quiet  = 0;
      if (num == 0) begin
        m_finishing = 1;
        exp_q.push_back(m_active);
      end else begin
        m_running = 1;
      end
    end
    if (wr) m_staging = wdata;
    m_e_tmo  = tmo  || (m_e_tmo  && !clr);
    m_e_spur = spur || (m_e_spur && !clr);
    m_e_drop = drop || (m_e_drop && !clr);
  endtask

  task automatic compare_all(input string ph);
    check({ph, ".rsc_z"},   32'(cfg_alu_src_rsc_z), 32'(m_active));
    check({ph, ".busy"},    32'(busy),              32'(m_running || m_finishing));
    check({ph, ".done"},    32'(layer_done),        32'(m_finishing));
    check({ph, ".ack_cnt"}, 32'(ack_cnt),           32'(m_cnt));
    check({ph, ".e_tmo"},   32'(err_timeout),       32'(m_e_tmo));
    check({ph, ".e_spur"},  32'(err_spurious),      32'(m_e_spur));
    check({ph, ".e_drop"},  32'(err_op_drop),       32'(m_e_drop));
    if (layer_done === 1'b1) begin
      if (exp_q.size() == 0) begin
        check({ph, ".sb_unexpected_done"}, 32'(1), 32'(0));
      end else begin
        check({ph, ".sb_layer_value"}, 32'(cfg_alu_src_rsc_z), 32'(exp_q.pop_front()));
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  // Called at a negedge: drive, let the DUT take the edge, then compare.
  task automatic cycle(input string ph, input bit wr, input logic [CFG_W-1:0] wdata,
                       input bit op, input int num, input bit clr, input bit lz);
    reg_wr_en   = wr;
    reg_wr_data = wdata;
    op_en       = op;
    cfg_ack_num = CNT_W'(num);
    err_clr     = clr;
    cfg_alu_src_rsc_triosy_lz = lz;
    @(posedge clk);
    model_step(wr, wdata, op, num, clr, lz);
    @(negedge clk);
    compare_all(ph);
  endtask

  task automatic idle(input string ph, input int n);
    for (int i = 0; i < n; i++) cycle(ph, 0, '0, 0, 0, 0, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1;
    reg_wr_en = 0; reg_wr_data = '0; op_en = 0; cfg_ack_num = '0;
    err_clr = 0; cfg_alu_src_rsc_triosy_lz = 0;
    model_reset();
    repeat (2) @(negedge clk);
    compare_all("reset");
    rst = 1'b0;

    // Basic layer: staging 1, three acks with a gap.
    cycle("basic", 1, 1'b1, 0, 0, 0, 0);
    cycle("basic", 0, '0,   1, 3, 0, 0);
    cycle("basic", 0, '0,   0, 0, 0, 1);
    cycle("basic", 0, '0,   0, 0, 0, 0);
    cycle("basic", 0, '0,   0, 0, 0, 1);
    cycle("basic", 0, '0,   0, 0, 0, 1);
    idle("basic", 2);

    // Bypass on start, hold during ACTIVE, next layer picks up the later write.
    cycle("bypass", 1, 1'b0, 0, 0, 0, 0);
    cycle("bypass", 1, 1'b1, 1, 2, 0, 0);
    cycle("bypass", 1, 1'b0, 0, 0, 0, 0);
    cycle("bypass", 0, '0,   0, 0, 0, 1);
    cycle("bypass", 0, '0,   0, 0, 0, 1);
    idle("bypass", 2);
    cycle("bypass", 0, '0,   1, 1, 0, 0);
    cycle("bypass", 0, '0,   0, 0, 0, 1);
    idle("bypass", 2);

    // Zero count layer.
    cycle("zero", 0, '0, 1, 0, 0, 0);
    idle("zero", 3);

    // Watchdog: one ack then silence.
    cycle("wdog", 0, '0, 1, 2, 0, 0);
    cycle("wdog", 0, '0, 0, 0, 0, 1);
    idle("wdog", 10);

    // Protocol errors and clearing.
    cycle("proto", 0, '0, 0, 0, 1, 0);
    cycle("proto", 0, '0, 0, 0, 0, 1);
    cycle("proto", 0, '0, 1, 2, 0, 0);
    cycle("proto", 0, '0, 1, 5, 0, 0);
    cycle("proto", 0, '0, 0, 0, 0, 1);
    cycle("proto", 0, '0, 0, 0, 0, 1);
    idle("proto", 2);
    cycle("proto", 0, '0, 0, 0, 1, 0);
    cycle("proto", 0, '0, 0, 0, 1, 1);
    cycle("proto", 0, '0, 0, 0, 1, 0);

    // Asynchronous reset after 2 of 4 acks.
    cycle("arst", 1, 1'b1, 1, 4, 0, 0);
    cycle("arst", 0, '0,   0, 0, 0, 1);
    cycle("arst", 0, '0,   0, 0, 0, 1);
    #2 rst = 1'b1;
    #1 model_reset();
    compare_all("arst_imm");
    @(negedge clk);
    compare_all("arst_hold");
    rst = 1'b0;
    cycle("arst_after", 1, 1'b1, 1, 1, 0, 0);
    cycle("arst_after", 0, '0,   0, 0, 0, 1);
    idle("arst_after", 2);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      cycle("rand",
            ($urandom_range(0, 3) == 0),
            CFG_W'($urandom),
            ($urandom_range(0, 7) == 0),
            ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 5),
            ($urandom_range(0, 15) == 0),
            ($urandom_range(0, 9) < 4));
    end
    idle("drain", 12);

    check("sb_empty", 32'(exp_q.size()), 32'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
